// File: rtl/mips_pkg.sv
// rtl/mips_pkg.sv - shared word width, reset PC default, fetch FSM encoding and FIFO entry layout
// Contents: WORD_W, FIFO_ENTRY_W, RESET_PC_DEFAULT, fetch_state_e, fifo_entry_t,
//           next_pc() (+4 modulo 2^32), word_align() (clears the byte offset).
package mips_pkg;

  localparam int WORD_W       = 32;
  localparam int FIFO_ENTRY_W = 2 * WORD_W;

  localparam logic [WORD_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } fetch_state_e;

  // Entry layout: {pc_plus_4[63:32], instruction[31:0]}
  typedef struct packed {
    logic [WORD_W-1:0] pc_plus_4;
    logic [WORD_W-1:0] instruction;
  } fifo_entry_t;

  // Plain 32-bit add; 0xFFFF_FFFC + 4 wraps to 0 by truncation.
  function automatic logic [WORD_W-1:0] next_pc(input logic [WORD_W-1:0] pc);
    return pc + 32'd4;
  endfunction

  function automatic logic [WORD_W-1:0] word_align(input logic [WORD_W-1:0] addr);
    return {addr[WORD_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/inst_fetch_unit_if.sv
// rtl/inst_fetch_unit_if.sv - fetch unit bus bundle: instruction memory, redirect and decode handshakes
// master: the fetch unit (drives imem_req_valid/imem_addr and the id_* outputs)
// slave : the environment (memory, MEM-stage redirect source, decode stage)
interface inst_fetch_unit_if;
  import mips_pkg::*;

  logic              imem_req_valid;
  logic              imem_req_ready;
  logic [WORD_W-1:0] imem_addr;
  logic              imem_rsp_valid;
  logic [WORD_W-1:0] imem_rsp_data;
  logic              redirect_valid;
  logic [WORD_W-1:0] redirect_pc;
  logic              id_valid;
  logic              id_ready;
  logic [WORD_W-1:0] id_instruction;
  logic [WORD_W-1:0] id_pc_plus_4;

  modport master (
    output imem_req_valid, imem_addr, id_valid, id_instruction, id_pc_plus_4,
    input  imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

  modport slave (
    input  imem_req_valid, imem_addr, id_valid, id_instruction, id_pc_plus_4,
    output imem_req_ready, imem_rsp_valid, imem_rsp_data, redirect_valid, redirect_pc, id_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - prefetch buffer, power-of-two depth, no bypass, flush clears contents
// Ports: clk, rst (async active-high), i_push/i_push_data, i_pop, i_flush,
//        o_head_data (oldest entry), o_count (occupancy), o_full.
module fetch_fifo #(
  parameter  int WIDTH = 64,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_data,
  input  logic             i_pop,
  input  logic             i_flush,
  output logic [WIDTH-1:0] o_head_data,
  output logic [CW-1:0]    o_count,
  output logic             o_full
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_full      = (r_count == CW'(DEPTH));
  assign o_count     = r_count;
  assign o_head_data = r_mem[r_rd_ptr];

  // Flush dominates; over/underflow attempts are dropped rather than corrupting the count.
  assign w_do_push = i_push & ~o_full & ~i_flush;
  assign w_do_pop  = i_pop & (r_count != '0) & ~i_flush;

  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_push_data;
    end
  end

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

endmodule

// File: rtl/inst_fetch_unit.sv
// rtl/inst_fetch_unit.sv - credit-based instruction prefetcher with redirect squashing
// Parameters: RESET_PC (first fetch address), FIFO_DEPTH (2, 4 or 8).
// Ports: clk, rst (async active-high), bus (inst_fetch_unit_if.master):
//   imem_req_valid/imem_req_ready/imem_addr   - fetch request
//   imem_rsp_valid/imem_rsp_data              - in-order fetch response
//   redirect_valid/redirect_pc                - taken branch/jump from MEM
//   id_valid/id_ready/id_instruction/id_pc_plus_4 - decode-side stream
module inst_fetch_unit
  import mips_pkg::*;
#(
  parameter logic [WORD_W-1:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int                FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  inst_fetch_unit_if.master   bus
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);

  fetch_state_e      r_state;
  logic [WORD_W-1:0] r_fetch_pc;
  logic [WORD_W-1:0] r_rsp_pc;       // fetch address of the next response that will be kept
  logic [CW-1:0]     r_outstanding;  // accepted requests not yet answered (stale ones included)
  logic [CW-1:0]     r_discard;      // responses still owed to requests made before a redirect

  logic [CW-1:0]     w_fifo_count;
  logic              w_fifo_full;
  fifo_entry_t       w_head;
  fifo_entry_t       w_push_entry;
  logic [CW:0]       w_credit_used;
  logic              w_credit_ok;
  logic              w_req_valid;
  logic              w_req_fire;
  logic              w_rsp_take;
  logic              w_rsp_keep;
  logic              w_id_valid;
  logic              w_pop;
  logic [CW-1:0]     w_outstanding_next;

  // Every outstanding request owns a FIFO slot, so a response can never find the FIFO full.
  assign w_credit_used = {1'b0, w_fifo_count} + {1'b0, r_outstanding};
  assign w_credit_ok   = (w_credit_used < (CW+1)'(FIFO_DEPTH));

  assign w_req_valid = (r_state == RUN) & w_credit_ok & ~bus.redirect_valid;
  assign w_req_fire  = w_req_valid & bus.imem_req_ready;

  // A response with nothing outstanding is spurious and ignored so counters cannot underflow.
  assign w_rsp_take = bus.imem_rsp_valid & (r_outstanding != '0);
  assign w_rsp_keep = w_rsp_take & ~bus.redirect_valid & (r_discard == '0);

  assign w_id_valid = (w_fifo_count != '0);
  assign w_pop      = w_id_valid & bus.id_ready & ~bus.redirect_valid;

  assign w_outstanding_next = r_outstanding + CW'(w_req_fire) - CW'(w_rsp_take);

  always_comb begin
    w_push_entry             = '0;
    w_push_entry.pc_plus_4   = next_pc(r_rsp_pc);
    w_push_entry.instruction = bus.imem_rsp_data;
  end

  fetch_fifo #(
    .WIDTH (FIFO_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_push      (w_rsp_keep & ~w_fifo_full),
    .i_push_data (w_push_entry),
    .i_pop       (w_pop),
    .i_flush     (bus.redirect_valid),
    .o_head_data (w_head),
    .o_count     (w_fifo_count),
    .o_full      (w_fifo_full)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state       <= BOOT;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_discard     <= '0;
    end else begin
      case (r_state)
        BOOT: r_state <= RUN;
        RUN:  r_state <= RUN;
      endcase

      r_outstanding <= w_outstanding_next;

      if (bus.redirect_valid) begin
        // Everything still in flight after this edge belongs to the old path.
        r_fetch_pc <= word_align(bus.redirect_pc);
        r_rsp_pc   <= word_align(bus.redirect_pc);
        r_discard  <= w_outstanding_next;
      end else begin
        if (w_req_fire) r_fetch_pc <= next_pc(r_fetch_pc);
        if (w_rsp_keep) r_rsp_pc   <= next_pc(r_rsp_pc);
        if (w_rsp_take && (r_discard != '0)) r_discard <= r_discard - CW'(1);
      end
    end
  end

  assign bus.imem_req_valid = w_req_valid;
  assign bus.imem_addr      = r_fetch_pc;
  assign bus.id_valid       = w_id_valid;
  // Gated so the data outputs read 0 whenever nothing valid is presented, including in reset.
  assign bus.id_instruction = w_id_valid ? w_head.instruction : '0;
  assign bus.id_pc_plus_4   = w_id_valid ? w_head.pc_plus_4   : '0;

endmodule

// File: tb/tb_inst_fetch_unit.sv
// tb/tb_inst_fetch_unit.sv - self-checking bench for inst_fetch_unit
module tb_inst_fetch_unit;

  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0000_0000;

  typedef struct { logic [31:0] addr; bit stale; } pend_t;
  typedef struct { logic [31:0] pc4; logic [31:0] ins; } ent_t;
  typedef struct { logic [31:0] addr; int due; } mreq_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  inst_fetch_unit_if bus ();
  inst_fetch_unit_if bus2 ();

  inst_fetch_unit #(.RESET_PC(RPC), .FIFO_DEPTH(DEPTH)) u_dut (
    .clk (clk), .rst (rst), .bus (bus)
  );

  inst_fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .FIFO_DEPTH(4)) u_dut_wrap (
    .clk (clk), .rst (rst), .bus (bus2)
  );

  int n_checks = 0;
  int n_err    = 0;
  int cyc      = 0;
  int lat      = 1;
  bit spurious = 0;

  // model: fetch pointer, in-flight requests (with stale marks) and buffered entries
  bit          m_boot;
  logic [31:0] m_pc;
  pend_t       m_pend[$];
  ent_t        m_fifo[$];
  mreq_t       mem_q[$];
  logic        e_rv;

  logic        last_rv, last_iv, last_fire;
  logic [31:0] last_addr, last_ins, last_pc4;

  logic [31:0] w_addrs[$];
  logic [31:0] w_pc4s[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic compare();
    logic [31:0] e_addr, e_ins, e_pc4;
    logic        e_iv;
    e_rv   = !rst && !m_boot && ((m_fifo.size() + m_pend.size()) < DEPTH) && !bus.redirect_valid;
    e_addr = rst ? RPC : m_pc;
    e_iv   = !rst && (m_fifo.size() != 0);
    e_ins  = e_iv ? m_fifo[0].ins : 32'h0;
    e_pc4  = e_iv ? m_fifo[0].pc4 : 32'h0;
    chk("imem_req_valid", bus.imem_req_valid, e_rv);
    chk("imem_addr",      bus.imem_addr,      e_addr);
    chk("id_valid",       bus.id_valid,       e_iv);
    chk("id_instruction", bus.id_instruction, e_ins);
    chk("id_pc_plus_4",   bus.id_pc_plus_4,   e_pc4);
    last_rv   = bus.imem_req_valid;
    last_iv   = bus.id_valid;
    last_addr = bus.imem_addr;
    last_ins  = bus.id_instruction;
    last_pc4  = bus.id_pc_plus_4;
    last_fire = bus.imem_req_valid & bus.imem_req_ready;
  endtask

  task automatic model_step();
    pend_t p;
    ent_t  e;
    bit    fire, rsp;
    if (rst) begin
      m_boot = 1;
      m_pc   = RPC;
      m_pend.delete();
      m_fifo.delete();
      mem_q.delete();
      return;
    end
    fire = e_rv && bus.imem_req_ready;
    rsp  = bus.imem_rsp_valid && (m_pend.size() > 0);
    if (bus.redirect_valid) begin
      if (rsp) void'(m_pend.pop_front());
      foreach (m_pend[i]) m_pend[i].stale = 1;
      m_fifo.delete();
      m_pc = {bus.redirect_pc[31:2], 2'b00};
    end else begin
      if (m_fifo.size() > 0 && bus.id_ready) void'(m_fifo.pop_front());
      if (rsp) begin
        p = m_pend.pop_front();
        if (!p.stale) begin
          e.pc4 = p.addr + 32'd4;
          e.ins = bus.imem_rsp_data;
          m_fifo.push_back(e);
        end
      end
      if (fire) begin
        p.addr  = m_pc;
        p.stale = 0;
        m_pend.push_back(p);
        m_pc = m_pc + 32'd4;
      end
    end
    m_boot = 0;
  endtask

  // One clock cycle: entered just after a rising edge with the inputs for this cycle set.
  task automatic cycle();
    mreq_t mq;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    if (!rst && mem_q.size() > 0 && mem_q[0].due <= cyc) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = mem_word(mem_q[0].addr);
      void'(mem_q.pop_front());
    end else if (!rst && spurious) begin
      bus.imem_rsp_valid = 1'b1;
      bus.imem_rsp_data  = 32'hDEAD_BEEF;
    end
    #3;
    compare();
    if (!rst && bus.imem_req_valid && bus.imem_req_ready) begin
      mq.addr = bus.imem_addr;
      mq.due  = cyc + lat;
      mem_q.push_back(mq);
    end
    model_step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Single-cycle memory and always-ready decode for the wrap-around instance.
  initial begin
    logic        acc2;
    logic [31:0] addr2;
    bus2.imem_req_ready = 1'b1;
    bus2.id_ready       = 1'b1;
    bus2.redirect_valid = 1'b0;
    bus2.redirect_pc    = 32'h0;
    bus2.imem_rsp_valid = 1'b0;
    bus2.imem_rsp_data  = 32'h0;
    forever begin
      @(negedge clk);
      acc2  = !rst && bus2.imem_req_valid && bus2.imem_req_ready;
      addr2 = bus2.imem_addr;
      if (!rst) begin
        if (acc2) w_addrs.push_back(addr2);
        if (bus2.id_valid) w_pc4s.push_back(bus2.id_pc_plus_4);
      end
      @(posedge clk);
      #1;
      bus2.imem_rsp_valid = acc2 && !rst;
      bus2.imem_rsp_data  = ~addr2;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int          nreq;
    bit          found;
    logic [31:0] got[$];
    logic [31:0] g;
    logic [31:0] wrap_a[3];
    logic [31:0] wrap_p[3];
    rst = 1'b1;
    bus.imem_req_ready = 1'b1;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = 32'h0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = 32'h0;
    bus.id_ready       = 1'b1;
    m_boot = 1;
    m_pc   = RPC;
    @(posedge clk);
    #1;
    repeat (2) cycle();
    chk("reset_req_valid", last_rv, 0);
    chk("reset_id_valid", last_iv, 0);

    // start-up stream with single-cycle memory
    rst = 1'b0;
    cycle(); chk("boot_no_request", last_rv, 0);
    cycle(); chk("first_addr", last_addr, 32'h0); chk("first_req_valid", last_rv, 1);
    cycle(); chk("second_addr", last_addr, 32'h4);
    cycle(); chk("third_addr", last_addr, 32'h8); chk("first_pc4", last_pc4, 32'h4);
    cycle(); chk("second_pc4", last_pc4, 32'h8);
    cycle(); chk("third_pc4", last_pc4, 32'hC);
    repeat (6) cycle();

    // memory back-pressure holds the address
    bus.imem_req_ready = 1'b0;
    repeat (3) cycle();
    bus.imem_req_ready = 1'b1;
    repeat (4) cycle();

    // decode stall from empty: credit rule limits issue to FIFO_DEPTH
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.id_ready = 1'b0;
    cycle();
    nreq = 0;
    repeat (10) begin cycle(); nreq += int'(last_fire); end
    chk("stall_request_count", nreq, 4);
    chk("stall_req_valid_low", last_rv, 0);
    spurious = 1; cycle(); spurious = 0;
    bus.id_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      cycle();
      chk("drain_order", last_pc4, 32'(4 * (k + 1)));
    end
    repeat (4) cycle();

    // latency 3, two in flight, redirect to 0x40
    rst = 1'b1; cycle(); rst = 1'b0;
    lat = 3;
    repeat (3) cycle();
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h40;
    cycle(); chk("redirect_cycle_no_req", last_rv, 0);
    bus.redirect_valid = 1'b0;
    cycle(); chk("redirect_target_addr", last_addr, 32'h40); chk("redirect_fifo_empty", last_iv, 0);
    found = 0;
    for (int k = 0; k < 20; k++) begin
      cycle();
      if (last_iv) begin found = 1; break; end
    end
    chk("redirect_first_found", found, 1);
    chk("redirect_first_pc4", last_pc4, 32'h44);
    lat = 1;
    repeat (8) cycle();

    // redirect coinciding with a response and a pop
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h0000_0103;
    cycle();
    bus.redirect_valid = 1'b0;
    cycle(); chk("collide_id_valid", last_iv, 0); chk("collide_addr", last_addr, 32'h100);
    repeat (8) cycle();

    // wrap-around of fetch address and pc+4
    bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFF8;
    cycle();
    bus.redirect_valid = 1'b0;
    for (int k = 0; k < 20 && got.size() < 3; k++) begin
      cycle();
      if (last_iv) got.push_back(last_pc4);
    end
    wrap_p = '{32'hFFFF_FFFC, 32'h0, 32'h4};
    for (int k = 0; k < 3; k++) begin
      g = (got.size() > k) ? got[k] : 32'hBAD0_0000;
      chk("redirect_wrap_pc4", g, wrap_p[k]);
    end

    // reset pulsed with three entries buffered
    rst = 1'b1; cycle(); rst = 1'b0;
    bus.id_ready = 1'b0;
    repeat (5) cycle();
    chk("pre_reset_id_valid", last_iv, 1);
    rst = 1'b1;
    cycle();
    chk("midreset_req_valid", last_rv, 0);
    chk("midreset_id_valid", last_iv, 0);
    chk("midreset_instruction", last_ins, 32'h0);
    chk("midreset_pc4", last_pc4, 32'h0);
    chk("midreset_addr", last_addr, RPC);
    rst = 1'b0;
    bus.id_ready = 1'b1;
    cycle();
    cycle(); chk("restart_addr", last_addr, RPC); chk("restart_req_valid", last_rv, 1);
    repeat (6) cycle();

    // RESET_PC = 0xFFFF_FFF8 instance
    wrap_a = '{32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000};
    for (int k = 0; k < 3; k++) begin
      g = (w_addrs.size() > k) ? w_addrs[k] : 32'hBAD0_0000;
      chk("wrap_inst_addr", g, wrap_a[k]);
      g = (w_pc4s.size() > k) ? w_pc4s[k] : 32'hBAD0_0000;
      chk("wrap_inst_pc4", g, wrap_p[k]);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
